// File: rtl/exec_pkg.sv
// Shared opcodes, FSM state type and branch shift for the execute_pipe stage.
package exec_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;
   localparam logic [3:0] ALU_NOR   = 4'b1100;
   localparam logic [3:0] ALU_MUL   = 4'b1000;

   localparam int unsigned BR_SHIFT = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MUL  = 1'b1
   } exec_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: N iterations after start, returns the low N bits of a*b.
module mul_iter #(
   parameter int unsigned N = 64
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         abort_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] product_o
);

   localparam int unsigned CntW = $clog2(N + 1);

   logic [N-1:0]    mcand_q;
   logic [N-1:0]    mplier_q;
   logic [N-1:0]    acc_q;
   logic [CntW-1:0] cnt_q;
   logic            busy_q;
   logic [N-1:0]    acc_sum;
   logic            last_iter;

   always_comb begin
      acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      last_iter = busy_q && (cnt_q == CntW'(N - 1));
   end

   // Product is the accumulator after the final add, so it is valid in the done cycle.
   assign busy_o    = busy_q;
   assign done_o    = last_iter;
   assign product_o = acc_sum;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (abort_i) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start_i && !busy_q) begin
         mcand_q  <= a_i;
         mplier_q <= b_i;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_sum;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CntW'(1);
         if (last_iter) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/execute_pipe.sv
// Registered LEGv8 execute stage with EX/MEM output register and valid/ready handshake.
// Define EXEC_MUL_EN to compile in the multi-cycle MUL operation (opcode 1000).
module execute_pipe
   import exec_pkg::*;
#(
   parameter int unsigned N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         AluSrc,
   input  logic [3:0]   AluControl,
   input  logic [N-1:0] PC_E,
   input  logic [N-1:0] signImm_E,
   input  logic [N-1:0] readData1_E,
   input  logic [N-1:0] readData2_E,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] PCBranch_M,
   output logic [N-1:0] aluResult_M,
   output logic [N-1:0] writeData_M,
   output logic         zero_M
);

   logic [N-1:0] alu_b;
   logic [N-1:0] alu_res;
   logic [N-1:0] pc_branch;
   logic         accept;
   logic         accept_alu;

   logic         out_valid_q;
   logic [N-1:0] pcb_q;
   logic [N-1:0] res_q;
   logic [N-1:0] wd_q;
   logic         zero_q;

   always_comb begin
      alu_b     = AluSrc ? signImm_E : readData2_E;
      pc_branch = PC_E + (signImm_E << BR_SHIFT);
      case (AluControl)
         ALU_AND:   alu_res = readData1_E & alu_b;
         ALU_OR:    alu_res = readData1_E | alu_b;
         ALU_ADD:   alu_res = readData1_E + alu_b;
         ALU_SUB:   alu_res = readData1_E - alu_b;
         ALU_PASSB: alu_res = alu_b;
         ALU_NOR:   alu_res = ~(readData1_E | alu_b);
         default:   alu_res = '0;
      endcase
   end

`ifdef EXEC_MUL_EN
   exec_state_t  state_q;
   logic         is_mul;
   logic         mul_start;
   logic         mul_busy;
   logic         mul_done;
   logic [N-1:0] mul_product;
   logic [N-1:0] pcb_hold_q;
   logic [N-1:0] wd_hold_q;

   always_comb begin
      in_ready   = (state_q == IDLE) && !mul_busy && !flush && (!out_valid_q || out_ready);
      accept     = in_valid && in_ready;
      is_mul     = (AluControl == ALU_MUL);
      mul_start  = accept && is_mul;
      accept_alu = accept && !is_mul;
   end

   mul_iter #(
      .N(N)
   ) u_mul_iter (
      .clk_i     (clk),
      .rst_ni    (reset),
      .start_i   (mul_start),
      .abort_i   (flush),
      .a_i       (readData1_E),
      .b_i       (alu_b),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_product)
   );
`else
   always_comb begin
      in_ready   = !flush && (!out_valid_q || out_ready);
      accept     = in_valid && in_ready;
      accept_alu = accept;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         pcb_q       <= '0;
         res_q       <= '0;
         wd_q        <= '0;
         zero_q      <= 1'b0;
`ifdef EXEC_MUL_EN
         state_q     <= IDLE;
         pcb_hold_q  <= '0;
         wd_hold_q   <= '0;
`endif
      end else if (flush) begin
         out_valid_q <= 1'b0;
`ifdef EXEC_MUL_EN
         state_q     <= IDLE;
`endif
      end else begin
         if (accept_alu) begin
            out_valid_q <= 1'b1;
            pcb_q       <= pc_branch;
            res_q       <= alu_res;
            wd_q        <= readData2_E;
            zero_q      <= (alu_res == '0);
`ifdef EXEC_MUL_EN
         end else if (mul_done) begin
            out_valid_q <= 1'b1;
            pcb_q       <= pcb_hold_q;
            res_q       <= mul_product;
            wd_q        <= wd_hold_q;
            zero_q      <= (mul_product == '0);
`endif
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
`ifdef EXEC_MUL_EN
         // Branch target and store data are captured at accept; operands may change during MUL.
         if (mul_start) begin
            pcb_hold_q <= pc_branch;
            wd_hold_q  <= readData2_E;
            state_q    <= MUL;
         end else if (mul_done) begin
            state_q    <= IDLE;
         end
`endif
      end
   end

   assign out_valid   = out_valid_q;
   assign PCBranch_M  = pcb_q;
   assign aluResult_M = res_q;
   assign writeData_M = wd_q;
   assign zero_M      = zero_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Directed self-checking bench for execute_pipe (N=64); MUL cases need EXEC_MUL_EN.
module tb_execute_pipe;
   import exec_pkg::*;

   localparam int unsigned N = 64;

   logic         clk;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic         AluSrc;
   logic [3:0]   AluControl;
   logic [N-1:0] PC_E;
   logic [N-1:0] signImm_E;
   logic [N-1:0] readData1_E;
   logic [N-1:0] readData2_E;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] PCBranch_M;
   logic [N-1:0] aluResult_M;
   logic [N-1:0] writeData_M;
   logic         zero_M;

   int n_checks;
   int n_fail;

   execute_pipe #(
      .N(N)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .AluSrc      (AluSrc),
      .AluControl  (AluControl),
      .PC_E        (PC_E),
      .signImm_E   (signImm_E),
      .readData1_E (readData1_E),
      .readData2_E (readData2_E),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .PCBranch_M  (PCBranch_M),
      .aluResult_M (aluResult_M),
      .writeData_M (writeData_M),
      .zero_M      (zero_M)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic src, input logic [63:0] pc,
                        input logic [63:0] imm, input logic [63:0] r1, input logic [63:0] r2);
      in_valid    = 1'b1;
      AluControl  = op;
      AluSrc      = src;
      PC_E        = pc;
      signImm_E   = imm;
      readData1_E = r1;
      readData2_E = r2;
   endtask

   task automatic check_res(input string tag, input logic [63:0] res, input logic zero);
      check({tag, "_v"}, 64'(out_valid), 64'd1);
      check({tag, "_res"}, aluResult_M, res);
      check({tag, "_z"}, 64'(zero_M), 64'(zero));
   endtask

   initial begin
      logic [63:0] held;
      int          lat;
      logic        bad;

      n_checks    = 0;
      n_fail      = 0;
      reset       = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      AluSrc      = 1'b0;
      AluControl  = 4'b0;
      PC_E        = '0;
      signImm_E   = '0;
      readData1_E = '0;
      readData2_E = '0;

      #12;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_res", aluResult_M, 64'd0);
      check("rst_pcb", PCBranch_M, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_ready", 64'(in_ready), 64'd1);

      // ADD with branch target
      drive(ALU_ADD, 1'b0, 64'h100, 64'd3, 64'd5, 64'd7);
      tick();
      check_res("add", 64'd12, 1'b0);
      check("add_pcb", PCBranch_M, 64'h10C);
      check("add_wd", writeData_M, 64'd7);

      // Back-to-back at full throughput
      drive(ALU_SUB, 1'b0, 64'h0, 64'd0, 64'd9, 64'd9);
      tick();
      check_res("sub_eq", 64'd0, 1'b1);
      drive(ALU_SUB, 1'b0, 64'h0, 64'd0, 64'd0, 64'd1);
      tick();
      check_res("sub_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      drive(ALU_AND, 1'b0, 64'h0, 64'd0, 64'hF0F0, 64'hFF00);
      tick();
      check_res("and", 64'hF000, 1'b0);
      drive(ALU_OR, 1'b0, 64'h0, 64'd0, 64'hF0F0, 64'hFF00);
      tick();
      check_res("or", 64'hFFF0, 1'b0);
      drive(ALU_NOR, 1'b0, 64'h0, 64'd0, 64'h0, 64'h0);
      tick();
      check_res("nor", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      drive(4'b0011, 1'b0, 64'h0, 64'd0, 64'd5, 64'd6);
      tick();
      check_res("badop", 64'd0, 1'b1);
`ifndef EXEC_MUL_EN
      drive(ALU_MUL, 1'b0, 64'h0, 64'd0, 64'd6, 64'd7);
      tick();
      check_res("mul_off", 64'd0, 1'b1);
`endif
      // Negative immediate: PCBranch = 0x1000 - 4
      drive(ALU_PASSB, 1'b1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h55);
      tick();
      check_res("passb", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      check("neg_pcb", PCBranch_M, 64'hFFC);
      check("passb_wd", writeData_M, 64'h55);

      // Backpressure holds the register and blocks accept
      held      = aluResult_M;
      out_ready = 1'b0;
      drive(ALU_ADD, 1'b0, 64'h0, 64'd0, 64'd1, 64'd1);
      #1;
      check("bp_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_hold", aluResult_M, held);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release", 64'(in_ready), 64'd1);
      tick();
      check_res("bp_load", 64'd2, 1'b0);
      in_valid = 1'b0;
      tick();
      check("drain", 64'(out_valid), 64'd0);

      // Flush squashes the output register and blocks accept
      drive(ALU_ADD, 1'b0, 64'h0, 64'd0, 64'd3, 64'd4);
      tick();
      check_res("pre_flush", 64'd7, 1'b0);
      drive(ALU_ADD, 1'b0, 64'h0, 64'd0, 64'd10, 64'd10);
      flush = 1'b1;
      #1;
      check("flush_ready", 64'(in_ready), 64'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_valid", 64'(out_valid), 64'd0);

`ifdef EXEC_MUL_EN
      // 6 x 7: result exactly N edges after accept
      drive(ALU_MUL, 1'b0, 64'h200, 64'd1, 64'd6, 64'd7);
      tick();
      in_valid = 1'b0;
      lat      = 0;
      bad      = 1'b0;
      while (!out_valid && lat < 80) begin
         if (in_ready) bad = 1'b1;
         tick();
         lat++;
      end
      check("mul_lat", 64'(lat), 64'd64);
      check("mul_busy_ready", 64'(bad), 64'd0);
      check_res("mul", 64'd42, 1'b0);
      check("mul_pcb", PCBranch_M, 64'h204);
      check("mul_wd", writeData_M, 64'd7);
      check("mul_ready_after", 64'(in_ready), 64'd1);

      drive(ALU_MUL, 1'b0, 64'h0, 64'd0, 64'h8000_0000_0000_0000, 64'd2);
      tick();
      in_valid = 1'b0;
      lat      = 0;
      while (!out_valid && lat < 80) begin
         tick();
         lat++;
      end
      check("mul2_lat", 64'(lat), 64'd64);
      check_res("mul_ovf", 64'd0, 1'b1);

      // Flush ten cycles into a MUL aborts it
      drive(ALU_MUL, 1'b0, 64'h0, 64'd0, 64'd3, 64'd3);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("mflush_valid", 64'(out_valid), 64'd0);
      check("mflush_ready", 64'(in_ready), 64'd1);
      drive(ALU_ADD, 1'b0, 64'h0, 64'd0, 64'd2, 64'd2);
      tick();
      in_valid = 1'b0;
      check_res("post_mflush", 64'd4, 1'b0);
      bad = 1'b0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (out_valid) bad = 1'b1;
      end
      check("mflush_no_late", 64'(bad), 64'd0);

      // Reset in the middle of a MUL
      drive(ALU_MUL, 1'b0, 64'h0, 64'd0, 64'd5, 64'd5);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b0;
      #1;
      check("mrst_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      bad   = 1'b0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (out_valid) bad = 1'b1;
      end
      check("mrst_no_late", 64'(bad), 64'd0);
`endif

      // Asynchronous reset with a valid result in the register
      drive(ALU_ADD, 1'b0, 64'h40, 64'd1, 64'd8, 64'd9);
      tick();
      in_valid = 1'b0;
      check_res("pre_rst", 64'd17, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_res", aluResult_M, 64'd0);
      check("mid_rst_pcb", PCBranch_M, 64'd0);
      check("mid_rst_wd", writeData_M, 64'd0);
      check("mid_rst_z", 64'(zero_M), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_ready", 64'(in_ready), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
